cgra_axi_rd_scheduler: RTL

//  Sequences strided single-beat AXI4 read streams for N_CH CGRA input channels onto one shared AR/R port.

---
 rtl/cgra_axi_rd_scheduler.sv | 224 ++++++++++++++++++++++
 1 files changed

// File: rtl/cgra_axi_rd_scheduler.sv
// Round-robin scheduler of strided single-beat AXI4 reads for N_CH CGRA input channels.
// Each channel walks base+offset in stride steps; R beats are steered back to their channel by ID.
module cgra_axi_rd_scheduler #(
  parameter int N_CH      = 4,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int MAX_OUTST = 4,
  parameter int ID_W      = $clog2(N_CH)
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic [N_CH-1:0]          cfg_start_i,
  input  logic [N_CH*ADDR_W-1:0]   cfg_addr_i,
  input  logic [N_CH*16-1:0]       cfg_size_i,
  input  logic [N_CH*16-1:0]       cfg_stride_i,
  output logic [N_CH-1:0]          busy_o,
  output logic [N_CH-1:0]          done_o,
  output logic [ADDR_W-1:0]        ar_addr_o,
  output logic [ID_W-1:0]          ar_id_o,
  output logic                     ar_valid_o,
  input  logic                     ar_ready_i,
  input  logic [ID_W-1:0]          r_id_i,
  input  logic [DATA_W-1:0]        r_data_i,
  input  logic                     r_valid_i,
  output logic                     r_ready_o,
  output logic [N_CH*DATA_W-1:0]   ch_data_o,
  output logic [N_CH-1:0]          ch_valid_o,
  input  logic [N_CH-1:0]          ch_ready_i
);

  localparam int OUT_W = $clog2(MAX_OUTST + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DRAIN = 2'd2
  } state_e;

  state_e            state_q  [N_CH];
  state_e            state_d  [N_CH];
  logic [ADDR_W-1:0] base_q   [N_CH];
  logic [ADDR_W-1:0] base_d   [N_CH];
  logic [15:0]       size_q   [N_CH];
  logic [15:0]       size_d   [N_CH];
  logic [15:0]       stride_q [N_CH];
  logic [15:0]       stride_d [N_CH];
  logic [16:0]       offset_q [N_CH];
  logic [16:0]       offset_d [N_CH];
  logic [OUT_W-1:0]  outst_q  [N_CH];
  logic [OUT_W-1:0]  outst_d  [N_CH];
  logic [N_CH-1:0]   done_q, done_d;

  logic [ADDR_W-1:0] ar_addr_q, ar_addr_d;
  logic [ID_W-1:0]   ar_id_q, ar_id_d;
  logic              ar_valid_q, ar_valid_d;
  logic [ID_W-1:0]   rr_q, rr_d;

  logic [ADDR_W-1:0] cfg_addr   [N_CH];
  logic [15:0]       cfg_size   [N_CH];
  logic [15:0]       cfg_stride [N_CH];
  logic [16:0]       offset_nxt [N_CH];

  logic [N_CH-1:0]   elig;
  logic [N_CH-1:0]   ch_load;
  logic [N_CH-1:0]   ch_dec;
  logic [N_CH-1:0]   last_load;
  logic              win_found;
  logic [ID_W-1:0]   win_idx;
  logic [ID_W:0]     scan_idx;
  logic              slot_load;
  logic              r_sel_known;
  logic              r_sel_ready;
  logic              r_sel_busy;
  logic              r_hs;

  for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
    assign cfg_addr[gi]   = cfg_addr_i[gi*ADDR_W +: ADDR_W];
    assign cfg_size[gi]   = cfg_size_i[gi*16 +: 16];
    assign cfg_stride[gi] = cfg_stride_i[gi*16 +: 16];

    assign offset_nxt[gi] = offset_q[gi] + {1'b0, stride_q[gi]};
    // A zero stride would never reach size, so it is treated as a single-beat stream.
    assign last_load[gi]  = (stride_q[gi] == 16'd0) || (offset_nxt[gi] >= {1'b0, size_q[gi]});

    assign elig[gi]    = (state_q[gi] == S_ISSUE) && (outst_q[gi] < OUT_W'(MAX_OUTST));
    assign ch_load[gi] = slot_load && (win_idx == ID_W'(gi));
    assign ch_dec[gi]  = r_hs && (r_id_i == ID_W'(gi)) && (outst_q[gi] != '0);

    assign busy_o[gi]     = (state_q[gi] != S_IDLE);
    assign ch_valid_o[gi] = r_valid_i && (r_id_i == ID_W'(gi));
    assign ch_data_o[gi*DATA_W +: DATA_W] = r_data_i;
  end

  // Rotating priority search starting at the round-robin pointer.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    scan_idx  = '0;
    for (int k = 0; k < N_CH; k++) begin
      scan_idx = {1'b0, rr_q} + (ID_W+1)'(k);
      if (scan_idx >= (ID_W+1)'(N_CH)) begin
        scan_idx = scan_idx - (ID_W+1)'(N_CH);
      end
      if (!win_found && elig[scan_idx[ID_W-1:0]]) begin
        win_found = 1'b1;
        win_idx   = scan_idx[ID_W-1:0];
      end
    end
  end

  assign slot_load = win_found && (!ar_valid_q || ar_ready_i);

  // Beats for unknown IDs or channels with nothing in flight are accepted and dropped.
  always_comb begin
    r_sel_known = 1'b0;
    r_sel_ready = 1'b0;
    r_sel_busy  = 1'b0;
    for (int c = 0; c < N_CH; c++) begin
      if (r_id_i == ID_W'(c)) begin
        r_sel_known = 1'b1;
        r_sel_ready = ch_ready_i[c];
        r_sel_busy  = (outst_q[c] != '0);
      end
    end
    r_ready_o = (r_sel_known && r_sel_busy) ? r_sel_ready : 1'b1;
  end

  assign r_hs = r_valid_i && r_ready_o;

  always_comb begin
    state_d    = state_q;
    base_d     = base_q;
    size_d     = size_q;
    stride_d   = stride_q;
    offset_d   = offset_q;
    outst_d    = outst_q;
    done_d     = '0;
    ar_addr_d  = ar_addr_q;
    ar_id_d    = ar_id_q;
    ar_valid_d = ar_valid_q;
    rr_d       = rr_q;

    for (int c = 0; c < N_CH; c++) begin
      if (ch_load[c] && !ch_dec[c]) begin
        outst_d[c] = outst_q[c] + 1'b1;
      end else if (!ch_load[c] && ch_dec[c]) begin
        outst_d[c] = outst_q[c] - 1'b1;
      end

      case (state_q[c])
        S_IDLE: begin
          if (cfg_start_i[c] && (cfg_size[c] != 16'd0)) begin
            base_d[c]   = cfg_addr[c];
            size_d[c]   = cfg_size[c];
            stride_d[c] = cfg_stride[c];
            offset_d[c] = '0;
            state_d[c]  = S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (ch_load[c]) begin
            offset_d[c] = offset_nxt[c];
            if (last_load[c]) begin
              state_d[c] = S_DRAIN;
            end
          end
        end
        S_DRAIN: begin
          if (outst_q[c] == '0) begin
            state_d[c] = S_IDLE;
            done_d[c]  = 1'b1;
          end
        end
        default: state_d[c] = S_IDLE;
      endcase
    end

    if (ar_valid_q && ar_ready_i) begin
      ar_valid_d = 1'b0;
    end
    if (slot_load) begin
      ar_valid_d = 1'b1;
      ar_addr_d  = base_q[win_idx] + ADDR_W'(offset_q[win_idx]);
      ar_id_d    = win_idx;
      rr_d       = (win_idx == ID_W'(N_CH - 1)) ? '0 : win_idx + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int c = 0; c < N_CH; c++) begin
        state_q[c]  <= S_IDLE;
        base_q[c]   <= '0;
        size_q[c]   <= '0;
        stride_q[c] <= '0;
        offset_q[c] <= '0;
        outst_q[c]  <= '0;
      end
      done_q     <= '0;
      ar_addr_q  <= '0;
      ar_id_q    <= '0;
      ar_valid_q <= 1'b0;
      rr_q       <= '0;
    end else begin
      state_q    <= state_d;
      base_q     <= base_d;
      size_q     <= size_d;
      stride_q   <= stride_d;
      offset_q   <= offset_d;
      outst_q    <= outst_d;
      done_q     <= done_d;
      ar_addr_q  <= ar_addr_d;
      ar_id_q    <= ar_id_d;
      ar_valid_q <= ar_valid_d;
      rr_q       <= rr_d;
    end
  end

  assign done_o     = done_q;
  assign ar_addr_o  = ar_addr_q;
  assign ar_id_o    = ar_id_q;
  assign ar_valid_o = ar_valid_q;

endmodule
